// File: rtl/acc_mem_arbiter.sv
// Shares one single-port word memory between a CPU, which always wins the port,
// and an accelerator that issues BEATS-word block reads and single-word writes.
module acc_mem_arbiter #(
    parameter int unsigned ADDR_SIZE      = 16,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned READ_DATA_SIZE = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // CPU side
    input  logic                      cpu_en,
    input  logic                      cpu_wr,
    input  logic [ADDR_SIZE-1:0]      cpu_addr,
    input  logic [WORD_SIZE-1:0]      cpu_wdata,
    output logic [WORD_SIZE-1:0]      cpu_rdata,
    // Accelerator block read
    input  logic                      acc_read_en,
    input  logic [ADDR_SIZE-1:0]      acc_read_addr,
    output logic [READ_DATA_SIZE-1:0] acc_read_data,
    output logic                      acc_read_data_valid,
    // Accelerator word write
    input  logic                      acc_write_en,
    input  logic [ADDR_SIZE-1:0]      acc_write_addr,
    input  logic [WORD_SIZE-1:0]      acc_write_data,
    output logic                      acc_write_done,
    // Memory port
    output logic                      mem_en,
    output logic                      mem_wr,
    output logic [ADDR_SIZE-1:0]      mem_addr,
    output logic [WORD_SIZE-1:0]      mem_wdata,
    input  logic [WORD_SIZE-1:0]      mem_rdata
);

    localparam int unsigned BEATS     = READ_DATA_SIZE / WORD_SIZE;
    localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        RD_LAST = 3'd2,
        RD_DONE = 3'd3,
        WRITE   = 3'd4,
        WR_DONE = 3'd5
    } state_e;

    state_e                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [BEAT_W-1:0]         cap_idx_q, cap_idx_d;
    logic                      cap_vld_q, cap_vld_d;
    logic [ADDR_SIZE-1:0]      addr_q, addr_d;
    logic [WORD_SIZE-1:0]      wdata_q, wdata_d;
    logic [READ_DATA_SIZE-1:0] rdata_q, rdata_d;
    logic                      valid_q, valid_d;
    logic                      done_q, done_d;

    logic                      acc_issue;
    logic                      acc_wr;
    logic [ADDR_SIZE-1:0]      acc_addr;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            cap_idx_q <= '0;
            cap_vld_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            cap_idx_q <= cap_idx_d;
            cap_vld_q <= cap_vld_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic and accelerator access for the current cycle
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        cap_idx_d = cap_idx_q;
        cap_vld_d = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        acc_issue = 1'b0;
        acc_wr    = 1'b0;
        acc_addr  = addr_q;

        unique case (state_q)
            IDLE: begin
                if (acc_read_en) begin
                    addr_d  = acc_read_addr;
                    beat_d  = '0;
                    state_d = READ;
                end else if (acc_write_en) begin
                    addr_d  = acc_write_addr;
                    wdata_d = acc_write_data;
                    state_d = WRITE;
                end
            end
            READ: begin
                // A CPU cycle steals the port; the beat counter simply holds.
                if (!cpu_en) begin
                    acc_issue = 1'b1;
                    acc_addr  = addr_q + ADDR_SIZE'(beat_q);
                    cap_vld_d = 1'b1;
                    cap_idx_d = beat_q;
                    beat_d    = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = RD_LAST;
                    end
                end
            end
            RD_LAST: begin
                valid_d = 1'b1;
                state_d = RD_DONE;
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            WRITE: begin
                if (!cpu_en) begin
                    acc_issue = 1'b1;
                    acc_wr    = 1'b1;
                    done_d    = 1'b1;
                    state_d   = WR_DONE;
                end
            end
            WR_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat capture follows the delayed issue flag, regardless of CPU traffic now
    always_comb begin
        rdata_d = rdata_q;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (cap_vld_q && (cap_idx_q == BEAT_W'(i))) begin
                rdata_d[i*WORD_SIZE +: WORD_SIZE] = mem_rdata;
            end
        end
    end

    // Memory port mux; in reset only the CPU may reach the memory
    always_comb begin
        if (cpu_en) begin
            mem_en    = 1'b1;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else begin
            mem_en    = acc_issue & rst_n;
            mem_wr    = acc_wr & rst_n;
            mem_addr  = acc_addr;
            mem_wdata = wdata_q;
        end
    end

    assign cpu_rdata           = mem_rdata;
    assign acc_read_data       = rdata_q;
    assign acc_read_data_valid = valid_q;
    assign acc_write_done      = done_q;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Bench for acc_mem_arbiter: behavioural memory, word-level reference contents,
// randomized data and CPU contention, directed timing checks.
module tb_acc_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_en, cpu_wr;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          acc_read_en;
    logic [AW-1:0] acc_read_addr;
    logic [RW-1:0] acc_read_data;
    logic          acc_read_data_valid;
    logic          acc_write_en;
    logic [AW-1:0] acc_write_addr;
    logic [DW-1:0] acc_write_data;
    logic          acc_write_done;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem_arr [0:65535];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [AW-1:0] rd_log [$];

    acc_mem_arbiter dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .cpu_en              (cpu_en),
        .cpu_wr              (cpu_wr),
        .cpu_addr            (cpu_addr),
        .cpu_wdata           (cpu_wdata),
        .cpu_rdata           (cpu_rdata),
        .acc_read_en         (acc_read_en),
        .acc_read_addr       (acc_read_addr),
        .acc_read_data       (acc_read_data),
        .acc_read_data_valid (acc_read_data_valid),
        .acc_write_en        (acc_write_en),
        .acc_write_addr      (acc_write_addr),
        .acc_write_data      (acc_write_data),
        .acc_write_done      (acc_write_done),
        .mem_en              (mem_en),
        .mem_wr              (mem_wr),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_rdata           (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory; also logs accelerator read addresses
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
            mem_rdata <= mem_arr[mem_addr];
        end
        if (mem_en && !mem_wr && !cpu_en) rd_log.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_block(input logic [AW-1:0] base);
        logic [RW-1:0] blk;
        logic [AW-1:0] a;
        blk = '0;
        for (int i = 0; i < 16; i++) begin
            a = base + AW'(i);
            blk[i*DW +: DW] = ref_mem[a];
        end
        return blk;
    endfunction

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cpu_en = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
        ref_mem[a] = d;
        @(negedge clk);
        cpu_en = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic cpu_read_check(input logic [AW-1:0] a);
        logic [DW-1:0] e;
        e = ref_mem[a];
        @(negedge clk);
        cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
        @(negedge clk);
        check("cpu_readback", RW'(cpu_rdata), RW'(e));
        cpu_en = 1'b0;
    endtask

    task automatic check_rd_addrs(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] ea;
        check("rd_beat_count", RW'(rd_log.size()), RW'(n));
        if (rd_log.size() == n) begin
            for (int k = 0; k < n; k++) begin
                ea = base + AW'(k);
                check("rd_beat_addr", RW'(rd_log[k]), RW'(ea));
            end
        end
    endtask

    // Block read with npulse CPU reads stolen from the READ window
    task automatic run_read(input logic [AW-1:0] base, input int npulse);
        bit            pulse_at [64];
        int            placed, c, lat;
        bit            chk_cpu;
        logic [DW-1:0] exp_cpu;
        logic [RW-1:0] blk;
        for (int i = 0; i < 64; i++) pulse_at[i] = 1'b0;
        placed = 0;
        while (placed < npulse) begin
            c = int'($urandom_range(14, 2));
            if (!pulse_at[c]) begin
                pulse_at[c] = 1'b1;
                placed++;
            end
        end
        blk = exp_block(base);
        rd_log.delete();
        chk_cpu = 1'b0;
        exp_cpu = '0;
        @(negedge clk);
        acc_read_en = 1'b1; acc_read_addr = base;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (chk_cpu) begin
                check("cpu_rdata_contended", RW'(cpu_rdata), RW'(exp_cpu));
                chk_cpu = 1'b0;
            end
            cpu_en = 1'b0;
            if (acc_read_data_valid) break;
            acc_read_addr = AW'($urandom);
            if (pulse_at[lat]) begin
                cpu_en = 1'b1; cpu_wr = 1'b0;
                cpu_addr = base + AW'($urandom_range(15, 0));
                exp_cpu = ref_mem[cpu_addr];
                chk_cpu = 1'b1;
            end
        end
        check("rd_latency", RW'(lat), RW'(18 + npulse));
        check("rd_data", acc_read_data, blk);
        acc_read_en = 1'b0;
        check_rd_addrs(base, 16);
        @(negedge clk);
        check("rd_valid_one_cycle", RW'(acc_read_data_valid), RW'(0));
    endtask

    task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        acc_write_en = 1'b1; acc_write_addr = a; acc_write_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        acc_write_addr = AW'($urandom); acc_write_data = $urandom;
        check("wr_mem_en", RW'(mem_en), RW'(1));
        check("wr_mem_wr", RW'(mem_wr), RW'(1));
        check("wr_mem_addr", RW'(mem_addr), RW'(a));
        check("wr_mem_wdata", RW'(mem_wdata), RW'(d));
        check("wr_done_early", RW'(acc_write_done), RW'(0));
        @(negedge clk);
        check("wr_done", RW'(acc_write_done), RW'(1));
        acc_write_en = 1'b0;
        @(negedge clk);
        check("wr_done_one_cycle", RW'(acc_write_done), RW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a, wa;
        logic [DW-1:0] wd;
        logic [RW-1:0] blk;
        int            lat, vlat, last, n, nvalid;

        rst_n = 1'b0; cpu_en = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        acc_read_en = 1'b0; acc_read_addr = '0;
        acc_write_en = 1'b0; acc_write_addr = '0; acc_write_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", RW'(acc_read_data_valid), RW'(0));
        check("rst_done", RW'(acc_write_done), RW'(0));
        check("rst_rdata", acc_read_data, RW'(0));
        check("rst_mem_en_idle", RW'(mem_en), RW'(0));
        cpu_en = 1'b1; cpu_addr = 16'h1234;
        #1;
        check("rst_mem_en_cpu", RW'(mem_en), RW'(1));
        check("rst_mem_addr_cpu", RW'(mem_addr), RW'(16'h1234));
        @(negedge clk);
        cpu_en = 1'b0; rst_n = 1'b1;

        // Uncontended and contended reads of word k = k+1
        for (int k = 0; k < 16; k++) cpu_write(16'h1000 + AW'(k), DW'(k + 1));
        run_read(16'h1000, 0);
        run_read(16'h1000, 3);

        // Single write, then eight back-to-back writes
        run_write(16'h5000, 32'h5);
        for (int k = 1; k < 8; k++) cpu_write(16'h5000 + AW'(k), $urandom);
        @(negedge clk);
        a = 16'h5008; wd = $urandom;
        acc_write_en = 1'b1; acc_write_addr = a; acc_write_data = wd; ref_mem[a] = wd;
        lat = 0; last = 0; n = 0;
        while (n < 8 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (acc_write_done) begin
                check("wr_b2b_gap", RW'(lat - last), RW'((n == 0) ? 2 : 3));
                last = lat;
                n++;
                if (n < 8) begin
                    a = 16'h5008 + AW'(n); wd = $urandom;
                    acc_write_addr = a; acc_write_data = wd; ref_mem[a] = wd;
                end else begin
                    acc_write_en = 1'b0;
                end
            end
        end
        acc_write_en = 1'b0;
        check("wr_b2b_count", RW'(n), RW'(8));
        run_read(16'h5000, 2);
        cpu_read_check(16'h500F);

        // Read and write together, read base wrapping past 0xFFFF
        for (int k = 0; k < 16; k++) cpu_write(16'hFFF8 + AW'(k), $urandom);
        blk = exp_block(16'hFFF8);
        wa = 16'h6000; wd = $urandom;
        rd_log.delete();
        @(negedge clk);
        acc_read_en = 1'b1; acc_read_addr = 16'hFFF8;
        acc_write_en = 1'b1; acc_write_addr = wa; acc_write_data = wd;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (acc_read_data_valid) break;
            acc_read_addr = AW'($urandom);
        end
        check("both_rd_latency", RW'(lat), RW'(18));
        check("both_rd_data", acc_read_data, blk);
        acc_read_en = 1'b0;
        vlat = lat;
        while (lat < vlat + 20) begin
            @(negedge clk);
            lat++;
            if (acc_write_done) break;
        end
        check("both_wr_after_valid", RW'(lat - vlat), RW'(3));
        acc_write_en = 1'b0;
        ref_mem[wa] = wd;
        check_rd_addrs(16'hFFF8, 16);
        cpu_read_check(wa);
        check("rd_data_stable", acc_read_data, blk);

        // Reset while beat 7 would issue aborts the read
        rd_log.delete();
        @(negedge clk);
        acc_read_en = 1'b1; acc_read_addr = 16'h1000;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_no_issue_in_rst", RW'(mem_en), RW'(0));
        @(negedge clk);
        rst_n = 1'b1; acc_read_en = 1'b0;
        check("abort_rdata_cleared", acc_read_data, RW'(0));
        check_rd_addrs(16'h1000, 7);
        nvalid = 0;
        repeat (25) begin
            @(negedge clk);
            if (acc_read_data_valid) nvalid++;
        end
        check("abort_no_valid", RW'(nvalid), RW'(0));
        run_read(16'h1000, 0);

        // Randomized blocks and contention
        for (int it = 0; it < 4; it++) begin
            a = AW'($urandom);
            for (int k = 0; k < 16; k++) cpu_write(a + AW'(k), $urandom);
            run_read(a, int'($urandom_range(4, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
